// File: rtl/l2_cacheline_adaptor.sv
// Bridges full-line L2 reads/writebacks to fixed-length memory bursts of narrower beats,
// reassembling read beats into one line and answering L2 with a single-cycle response.
module l2_cacheline_adaptor #(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned BURST_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int unsigned NUM_BURSTS = LINE_WIDTH / BURST_WIDTH;
  localparam int unsigned CNT_W      = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int unsigned OFFSET_W   = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BURSTS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [LINE_WIDTH-1:0]   buffer;
  logic [ADDR_WIDTH-1:0]   addr_aligned;

  assign addr_aligned = {address_i[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
  assign line_o       = buffer;
  // Write data follows the beat counter so a stalled beat stays on the bus.
  assign burst_o      = buffer[int'(cnt)*BURST_WIDTH +: BURST_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      buffer    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_o <= 1'b0;
          // Writeback is served before the fill when both are requested.
          if (write_i) begin
            buffer    <= line_i;
            address_o <= addr_aligned;
            cnt       <= '0;
            write_o   <= 1'b1;
            state     <= WR_BURST;
          end else if (read_i) begin
            address_o <= addr_aligned;
            cnt       <= '0;
            read_o    <= 1'b1;
            state     <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            buffer[int'(cnt)*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
            if (cnt == LAST_BEAT) begin
              cnt    <= '0;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            if (cnt == LAST_BEAT) begin
              cnt     <= '0;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          // Requests still held during the response cycle are deliberately ignored.
          resp_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Self-checking bench for l2_cacheline_adaptor: directed scenarios plus randomized
// transactions checked against a transaction-level model of line/beat transfers.
module tb_l2_cacheline_adaptor;

  localparam int unsigned LW = 256;
  localparam int unsigned BW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned NB = LW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] line_i;
  logic [LW-1:0] line_o;
  logic [AW-1:0] address_i;
  logic          read_i;
  logic          write_i;
  logic          resp_o;
  logic [BW-1:0] burst_i;
  logic [BW-1:0] burst_o;
  logic [AW-1:0] address_o;
  logic          read_o;
  logic          write_o;
  logic          resp_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [LW-1:0] last_line;

  l2_cacheline_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rnd_beat();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int i = 0; i < int'(NB); i++) v[i*BW +: BW] = rnd_beat();
    return v;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_resp"}, LW'(resp_o), LW'(0));
    chk({tag, "_rd"}, LW'(read_o), LW'(0));
    chk({tag, "_wr"}, LW'(write_o), LW'(0));
  endtask

  // One line transfer: a write when wr is set (wins over rd), otherwise a read whose
  // memory beats are the slices of data. stall<0 picks 0..2 random stalls per beat.
  task automatic xfer(input bit wr, input bit rd, input logic [AW-1:0] addr,
                      input logic [LW-1:0] data, input int stall);
    logic [AW-1:0] exp_addr;
    logic [BW-1:0] beat;
    int s, sched, seen;
    exp_addr = addr & ~AW'(32'h1f);
    write_i = wr; read_i = rd; address_i = addr;
    line_i = wr ? data : rnd_line();
    resp_i = 1'b0; burst_i = rnd_beat();
    step();
    address_i = $urandom; line_i = rnd_line();
    sched = 0; seen = 0;
    for (int k = 0; k < int'(NB); k++) begin
      beat = data[k*BW +: BW];
      s = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      for (int j = 0; j <= s; j++) begin
        resp_i  = (j == s);
        burst_i = (j == s) ? beat : rnd_beat();
        chk("busy_rd", LW'(read_o), LW'(!wr));
        chk("busy_wr", LW'(write_o), LW'(wr));
        chk("busy_resp", LW'(resp_o), LW'(0));
        chk("busy_addr", LW'(address_o), LW'(exp_addr));
        if (wr) chk("burst_o", LW'(burst_o), LW'(beat));
        if (read_o || write_o) seen++;
        sched++;
        step();
      end
    end
    resp_i = 1'b0; burst_i = rnd_beat();
    chk("done_resp", LW'(resp_o), LW'(1));
    chk("done_rd", LW'(read_o), LW'(0));
    chk("done_wr", LW'(write_o), LW'(0));
    chk("done_line", line_o, data);
    chk("busy_cycles", LW'(seen), LW'(sched));
    step();
    chk_quiet("after_done");
    chk("hold_addr", LW'(address_o), LW'(exp_addr));
    last_line = data;
  endtask

  task automatic idle(input int n);
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    repeat (n) step();
  endtask

  initial begin : main
    logic [LW-1:0] d;
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    step(); step();
    chk_quiet("reset");
    chk("reset_addr", LW'(address_o), LW'(0));
    chk("reset_line", line_o, LW'(0));
    chk("reset_burst", LW'(burst_o), LW'(0));
    rst = 1'b0;
    idle(1);

    // Read fill, no stalls, fixed beats.
    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    xfer(1'b0, 1'b1, 32'h0000_1234, d, 0);
    chk("fill_addr", LW'(address_o), LW'(32'h0000_1220));
    idle(1);

    // Writeback with two stall cycles before every beat: 12 busy cycles.
    xfer(1'b1, 1'b0, $urandom, rnd_line(), 2);
    idle(2);

    // Simultaneous request: write first, then the still-held read chains on.
    xfer(1'b1, 1'b1, $urandom, rnd_line(), -1);
    xfer(1'b0, 1'b1, $urandom, rnd_line(), -1);
    idle(1);

    // Reset after two read beats discards the partial line.
    read_i = 1'b1; address_i = $urandom;
    step();
    read_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = rnd_beat();
      step();
    end
    rst = 1'b1; resp_i = 1'b0;
    step();
    chk_quiet("midrst");
    chk("midrst_line", line_o, LW'(0));
    chk("midrst_addr", LW'(address_o), LW'(0));
    rst = 1'b0;
    idle(1);
    xfer(1'b0, 1'b1, $urandom, rnd_line(), -1);
    idle(1);

    // Stray memory responses while idle change nothing.
    for (int k = 0; k < 3; k++) begin
      resp_i = 1'b1; burst_i = rnd_beat();
      step();
      chk_quiet("stray");
      chk("stray_line", line_o, last_line);
    end
    resp_i = 1'b0;
    xfer(1'b0, 1'b1, $urandom, rnd_line(), 0);
    idle(1);

    // Randomized transactions.
    for (int t = 0; t < 20; t++) begin
      bit wr, rd;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      xfer(wr, rd, $urandom, rnd_line(), -1);
      idle(int'($urandom_range(1, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l2_cacheline_adaptor.md
Name: l2_cacheline_adaptor

Overview:
- Sits directly downstream of the L2 cache controller, between the L2 line interface and physical memory.
- Converts each single-request, full-cacheline L2 read or writeback into a fixed-length burst of narrower memory beats.
- Converts each memory burst back into one full line with a single-cycle response.
- The L2 controller holds its request until it sees the response; memory returns one beat per resp_i pulse.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits.
- BURST_WIDTH, 64, memory beat width in bits. LINE_WIDTH must be an integer multiple of BURST_WIDTH.
- ADDR_WIDTH, 32, byte address width.
- NUM_BURSTS, LINE_WIDTH/BURST_WIDTH (4), number of beats per line. Derived; do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- line_i  in  LINE_WIDTH  writeback data from L2.
- line_o  out  LINE_WIDTH  fill data to L2.
- address_i  in  ADDR_WIDTH  L2 line address.
- read_i  in  1  L2 line read request.
- write_i  in  1  L2 line write request.
- resp_o  out  1  line transfer complete, one-cycle pulse.
- burst_i  in  BURST_WIDTH  memory read beat.
- burst_o  out  BURST_WIDTH  memory write beat.
- address_o  out  ADDR_WIDTH  line-aligned memory address.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat accepted (write) or beat valid (read).

Behaviour:
- Reset (synchronous, active-high rst):
  - state=IDLE, beat counter=0, line buffer=0, address register=0.
  - All outputs 0: resp_o, read_o, write_o, address_o, burst_o, line_o.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - write_i=1 -> latch line_i into buffer, latch address_i with low log2(LINE_WIDTH/8) bits forced to 0, counter=0, go WR_BURST.
  - Else read_i=1 -> latch aligned address, counter=0, go RD_BURST.
  - Write wins when read_i and write_i are both asserted (writeback precedes fill).
  - resp_i in IDLE is ignored.
- RD_BURST:
  - read_o=1, address_o=latched address.
  - On each cycle with resp_i=1: buffer[counter*BURST_WIDTH +: BURST_WIDTH] <= burst_i, counter++.
  - On the beat with counter==NUM_BURSTS-1: go DONE and clear counter.
  - Cycles without resp_i: hold all state.
- WR_BURST:
  - write_o=1, address_o=latched address, burst_o=buffer[counter*BURST_WIDTH +: BURST_WIDTH] (combinational from counter).
  - resp_i=1 advances the counter; after the last beat, go DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0.
  - Unconditionally return to IDLE on the next edge.
  - read_i/write_i sampled in DONE are ignored, so a request still held during the response cycle does not restart a transfer.
- line_o:
  - Driven from the buffer at all times.
  - Valid in the DONE cycle of a read; holds its value until the next transfer overwrites the buffer.
- Latency:
  - Request sampled at edge N -> read_o/write_o high from cycle N+1.
  - With resp_i held high, the 4 beats occupy cycles N+1..N+4 and resp_o is high in cycle N+5.
  - Each resp_i stall cycle adds one cycle.
- Counter:
  - Width is log2(NUM_BURSTS).
  - The counter never wraps mid-transfer; it is cleared on entry to a burst and on DONE.
- read_o and write_o are never both 1. Outside burst states, address_o holds the last latched address.
- Reset mid-burst: next cycle is IDLE with all outputs 0. The partial line is discarded and no resp_o is issued. Memory-side abort is the system's responsibility.
- address_i, line_i and burst_i are don't-care outside their sampling cycles.

Test Plan:
- Read fill, no stalls: read_i=1, address_i=0x0000_1234, burst_i beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp_i=1 in cycles 1-4 -> address_o=0x0000_1220, read_o high for 4 cycles, resp_o pulses in cycle 5, line_o={0x44..,0x33..,0x22..,0x11..}.
- Writeback with stalls: write_i=1, line_i={D3,D2,D1,D0}, resp_i low 2 cycles before each beat -> burst_o shows D0, D1, D2, D3 in order and holds during stalls; write_o high 12 cycles; single resp_o pulse.
- Simultaneous read_i=write_i=1 -> write burst executes first. With read_i held after resp_o, the next transfer is a read starting the cycle after IDLE is re-entered.
- Request held through DONE: read_i stays 1 during the resp_o cycle -> exactly one resp_o, then a new read starts only after IDLE samples it, at least 1 cycle gap.
- Reset after 2 beats of a read -> next cycle: read_o=0, resp_o=0, line_o=0; a subsequent read completes normally with 4 fresh beats.
- Stray resp_i pulses while IDLE -> no state change, no resp_o, counter remains 0.
